// File: rtl/alu_op_sequencer_pkg.sv
// alu_op_sequencer_pkg: sequencer states, modulo select code and default data width
package alu_op_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, COMB, MOD_RUN, RESP} state_t;
  localparam logic [2:0] SEL_MOD = 3'b111;
  localparam int DEFAULT_DATA_W = 32;
endpackage

// File: rtl/alu_op_timeout_cnt.sv
// alu_op_timeout_cnt: counts MOD_RUN cycles and flags the cycle in which the wait limit is reached
module alu_op_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign cnt_d = run ? cnt_q + 1'b1 : '0;
  assign expired = run && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: valid/ready sequencer in front of the ALU; optional modulo timeout via ALU_OP_SEQUENCER_TIMEOUT_EN
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [2:0]        req_sel,
  input  logic              req_cin,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_sel,
  output logic              alu_cin,
  output logic              alu_start,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_cout,
  input  logic              alu_done,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_cout,
  output logic              rsp_err
);
  state_t state_q, state_d;
  logic [DATA_W-1:0] a_q, b_q, res_q, res_d;
  logic [2:0] sel_q;
  logic cin_q, cout_q, cout_d, accept, mod_end, capture, take, tmo;
  assign accept = state_q == IDLE && req_valid;
  assign mod_end = state_q == MOD_RUN && (alu_done || tmo);
  assign capture = state_q == COMB || mod_end;
  assign take = state_q == COMB || alu_done;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = req_valid ? (req_sel == SEL_MOD ? MOD_RUN : COMB) : IDLE;
      COMB:    state_d = RESP;
      MOD_RUN: state_d = mod_end ? RESP : MOD_RUN;
      RESP:    state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
    res_d = capture ? (take ? alu_result : '0) : res_q;
    cout_d = capture ? (take ? alu_cout : 1'b0) : cout_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sel_q <= '0;
      cin_q <= 1'b0;
      res_q <= '0;
      cout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q <= res_d;
      cout_q <= cout_d;
      if (accept) begin
        a_q <= req_a;
        b_q <= req_b;
        sel_q <= req_sel;
        cin_q <= req_cin;
      end
    end
`ifdef ALU_OP_SEQUENCER_TIMEOUT_EN
  logic err_q;
  alu_op_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk(clk),
    .reset(reset),
    .run(alu_start),
    .expired(tmo)
  );
  // a done arriving in the timeout cycle still counts as success
  always_ff @(posedge clk or posedge reset)
    if (reset) err_q <= 1'b0;
    else if (capture) err_q <= mod_end && !alu_done;
  assign rsp_err = err_q;
`else
  assign tmo = 1'b0;
  assign rsp_err = 1'b0;
`endif
  assign req_ready = state_q == IDLE && !reset;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_sel = sel_q;
  assign alu_cin = cin_q;
  assign alu_start = state_q == MOD_RUN;
  assign rsp_valid = state_q == RESP;
  assign rsp_result = res_q;
  assign rsp_cout = cout_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench with a stub ALU (add with carry, modulo with programmable done delay)
module tb_alu_op_sequencer;
  typedef struct {
    logic [31:0] res;
    logic        cout;
    logic        err;
  } exp_t;
  logic clk = 1'b0, reset;
  logic req_valid, req_ready, req_cin, alu_cin, alu_start, alu_cout, alu_done;
  logic rsp_valid, rsp_ready, rsp_cout, rsp_err;
  logic [31:0] req_a, req_b, alu_a, alu_b, alu_result, rsp_result;
  logic [2:0] req_sel, alu_sel;
  logic [32:0] sum;
  logic done_never, force_done;
  int d_delay, dcnt, cyc, checks, failures;
  exp_t exp_q[$];
  exp_t e;
  alu_op_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .req_cin(req_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_start(alu_start), .alu_result(alu_result), .alu_cout(alu_cout), .alu_done(alu_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_cout(rsp_cout), .rsp_err(rsp_err)
  );
  always #5 clk = ~clk;
  assign sum = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
  assign alu_result = alu_sel == 3'b111 ? (alu_b != 0 ? alu_a % alu_b : 32'd0) : sum[31:0];
  assign alu_cout = alu_sel == 3'b111 ? 1'b0 : sum[32];
  assign alu_done = force_done | (alu_start && !done_never && dcnt == d_delay - 1);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    dcnt <= alu_start ? dcnt + 1 : 0;
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp got=%0h exp=none", rsp_result);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_result", 64'(rsp_result), 64'(e.res));
        chk("rsp_cout", 64'(rsp_cout), 64'(e.cout));
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel,
                      input logic cin, input bit push, input logic [31:0] er, input logic ec,
                      input logic ee, input bit keep, output int hs);
    @(posedge clk); #1;
    if (push) exp_q.push_back('{res: er, cout: ec, err: ee});
    req_valid = 1'b1;
    req_a = a;
    req_b = b;
    req_sel = sel;
    req_cin = cin;
    hs = -1;
    for (int i = 0; i < 200 && hs < 0; i++) begin
      @(negedge clk);
      if (req_ready) hs = cyc;
    end
    if (hs < 0) begin
      checks++;
      failures++;
      $display("FAIL req_handshake got=timeout exp=accept");
    end
    @(posedge clk); #1;
    if (!keep) req_valid = 1'b0;
  endtask
  task automatic wait_rsp(output int c);
    c = -1;
    for (int i = 0; i < 300 && c < 0; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) c = cyc;
    end
    if (c < 0) begin
      checks++;
      failures++;
      $display("FAIL rsp_wait got=timeout exp=response");
    end
  endtask
  task automatic count_starts(output int n, output bit busy_ok);
    bit seen = 0;
    n = 0;
    busy_ok = 1;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
      else begin
        if (alu_start) n++;
        if (req_ready) busy_ok = 0;
      end
    end
  endtask
  initial begin
    int hs, hs2, hs3, c, n;
    bit ok;
    logic [31:0] held;
    reset = 1'b1;
    req_valid = 1'b0;
    req_a = '0;
    req_b = '0;
    req_sel = '0;
    req_cin = 1'b0;
    rsp_ready = 1'b1;
    d_delay = 20;
    done_never = 1'b0;
    force_done = 1'b0;
    cyc = 0;
    dcnt = 0;
    checks = 0;
    failures = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_alu_ops", {alu_a, alu_b}, 0);
    chk("rst_alu_ctl", {alu_sel, alu_cin, alu_start}, 0);
    chk("rst_rsp", {rsp_valid, rsp_cout, rsp_err, rsp_result}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 64'(req_ready), 1);
    // 1: plain add, latency check
    send(100, 60, 3'b000, 1'b0, 1, 160, 1'b0, 1'b0, 0, hs);
    @(negedge clk);
    chk("alu_a_held", 64'(alu_a), 100);
    chk("alu_b_held", 64'(alu_b), 60);
    wait_rsp(c);
    chk("add_latency", 64'(c - hs), 2);
    // 2: add with carry-out
    send(32'hFFFF_FFFF, 1, 3'b000, 1'b0, 1, 0, 1'b1, 1'b0, 0, hs);
    wait_rsp(c);
    // 3: modulo with back-pressure
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    d_delay = 20;
    send(100, 6, 3'b111, 1'b0, 1, 4, 1'b0, 1'b0, 0, hs);
    count_starts(n, ok);
    chk("mod_start_cycles", 64'(n), 20);
    chk("mod_req_ready_low", 64'(ok && !req_ready), 1);
    chk("mod_start_low_in_resp", 64'(alu_start), 0);
    held = rsp_result;
    ok = 1;
    repeat (5) begin
      @(negedge clk);
      if (!rsp_valid || rsp_result !== held || req_ready) ok = 0;
    end
    chk("mod_rsp_stable", 64'(ok), 1);
    chk("mod_held_result", 64'(held), 4);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_rsp(c);
    @(negedge clk);
    chk("after_accept_valid", 64'(rsp_valid), 0);
    chk("after_accept_ready", 64'(req_ready), 1);
    // stray done outside MOD_RUN must be ignored
    @(posedge clk); #1;
    force_done = 1'b1;
    @(posedge clk); #1;
    force_done = 1'b0;
    @(negedge clk);
    chk("stray_done", {rsp_valid, req_ready, alu_start}, 3'b010);
`ifdef ALU_OP_SEQUENCER_TIMEOUT_EN
    // 4: timeout, then done coinciding with the timeout cycle
    done_never = 1'b1;
    send(100, 6, 3'b111, 1'b0, 1, 0, 1'b0, 1'b1, 0, hs);
    count_starts(n, ok);
    chk("tmo_start_cycles", 64'(n), 64);
    wait_rsp(c);
    done_never = 1'b0;
    d_delay = 64;
    send(100, 7, 3'b111, 1'b0, 1, 2, 1'b0, 1'b0, 0, hs);
    count_starts(n, ok);
    chk("tmo_tie_start_cycles", 64'(n), 64);
    wait_rsp(c);
`endif
    // 5: reset mid-modulo aborts without a response
    d_delay = 1000;
    send(5, 3, 3'b111, 1'b0, 0, 0, 1'b0, 1'b0, 0, hs);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_outputs", {alu_start, rsp_valid, req_ready}, 0);
    chk("abort_alu_a", 64'(alu_a), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    d_delay = 20;
    send(7, 8, 3'b000, 1'b0, 1, 15, 1'b0, 1'b0, 0, hs);
    wait_rsp(c);
    // 6: back-to-back queued adds with req_valid held high
    send(1, 2, 3'b000, 1'b1, 1, 4, 1'b0, 1'b0, 1, hs);
    send(32'h8000_0000, 32'h8000_0000, 3'b000, 1'b0, 1, 0, 1'b1, 1'b0, 1, hs2);
    send(10, 20, 3'b000, 1'b0, 1, 30, 1'b0, 1'b0, 0, hs3);
    chk("b2b_spacing_1", 64'(hs2 - hs), 3);
    chk("b2b_spacing_2", 64'(hs3 - hs2), 3);
    repeat (6) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Request-side sequencer directly upstream of the 32-bit ALU; it feeds the ALU and collects its result.
- Accepts one operation at a time on a valid/ready request channel and drives the ALU operand, select and carry inputs from registers.
- For select 3'b111 (modulo, multi-cycle), runs the ALU's start/done handshake.
- Returns the result, carry-out and an error flag on a valid/ready response channel.

## Interface
Parameters:
- DATA_W, 32, operand/result width; must match the ALU.
- TIMEOUT_CYCLES, 64, maximum cycles to wait for alu_done; used only when the timeout feature is compiled in.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; returns the block to IDLE immediately.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_a  in  DATA_W  operand A.
- req_b  in  DATA_W  operand B.
- req_sel  in  3  ALU select.
- req_cin  in  1  carry-in.
- alu_a  out  DATA_W  registered operand A to the ALU.
- alu_b  out  DATA_W  registered operand B to the ALU.
- alu_sel  out  3  registered select to the ALU.
- alu_cin  out  1  registered carry-in to the ALU.
- alu_start  out  1  modulo start, level.
- alu_result  in  DATA_W  ALU result.
- alu_cout  in  1  ALU carry-out.
- alu_done  in  1  modulo complete.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  DATA_W  captured result.
- rsp_cout  out  1  captured carry-out.
- rsp_err  out  1  modulo timed out.

## Operation
FSM states: IDLE, COMB, MOD_RUN, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, register req_a, req_b, req_sel and req_cin into the alu_* outputs.
  - Go to MOD_RUN if req_sel==3'b111, otherwise go to COMB.
- COMB:
  - One settle cycle.
  - At the end of the cycle, capture alu_result and alu_cout into the rsp_* registers, clear rsp_err, go to RESP.
- MOD_RUN:
  - alu_start=1.
  - When alu_done==1 is sampled, capture alu_result and alu_cout, deassert alu_start, go to RESP.
- RESP:
  - rsp_valid=1.
  - rsp_* outputs stay stable until rsp_valid&&rsp_ready, then go to IDLE.
- req_ready is high only in IDLE. A request arriving in any other state is held off and is not lost.
- alu_* operand, select and carry-in outputs hold their value from acceptance until the next acceptance.
- rsp_cout is captured for every operation. For modulo it is whatever the ALU drives; the block does not interpret it.
- An alu_done pulse seen outside MOD_RUN is ignored.
- Reset at any time, including mid-MOD_RUN:
  - state goes to IDLE;
  - alu_start, rsp_valid and rsp_err go to 0;
  - every data output clears to 0.
  - No response is produced for an aborted operation.
- Reset values of all outputs:
  - req_ready=1 once reset is released; while reset is high, req_ready=0.
  - alu_a=0, alu_b=0, alu_sel=0, alu_cin=0, alu_start=0.
  - rsp_valid=0, rsp_result=0, rsp_cout=0, rsp_err=0.

## Timing
- Cycle N: req_valid&&req_ready handshake.
- N+1: state COMB (or MOD_RUN); alu_* outputs carry the new operation.
- Combinational operation: capture at the end of N+1; rsp_valid is high from N+2.
- Modulo operation:
  - alu_start is high from N+1.
  - If alu_done is sampled high in cycle M, alu_start is low and rsp_valid high from M+1.
- Response accepted in cycle R: rsp_valid=0 and req_ready=1 at R+1.
- Minimum spacing between accepted combinational requests is 3 cycles when rsp_ready is held high.

## Configuration
Macro: ALU_OP_SEQUENCER_TIMEOUT_EN.
- Defined:
  - A cycle counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to MOD_RUN and increments each MOD_RUN cycle.
  - If it reaches TIMEOUT_CYCLES with alu_done still low: alu_start drops, rsp_result=0, rsp_cout=0, rsp_err=1, go to RESP.
  - If alu_done and the timeout occur in the same cycle, done wins and rsp_err=0.
- Not defined:
  - No counter is built.
  - MOD_RUN waits for alu_done indefinitely.
  - rsp_err is tied to 0.

## Structure
- Package alu_op_sequencer_pkg holds:
  - the state enum;
  - SEL_MOD = 3'b111;
  - the default DATA_W.
- One sub-module, alu_op_timeout_cnt: the timeout counter, instantiated only when ALU_OP_SEQUENCER_TIMEOUT_EN is defined.
- The FSM and the capture registers stay in the top module.

## Test plan
The bench uses a stub ALU: sel 000 = add with carry; sel 111 = modulo with a programmable done delay D.
1. Add, no back-pressure:
   - Stimulus: a=100, b=60, sel=000, cin=0, rsp_ready=1.
   - Required: rsp_result=160, rsp_cout=0, rsp_valid two cycles after the handshake.
2. Add with carry-out:
   - Stimulus: a=32'hFFFFFFFF, b=1, sel=000.
   - Required: rsp_result=0, rsp_cout=1.
3. Modulo with back-pressure:
   - Stimulus: a=100, b=6, sel=111, D=20, rsp_ready held low for 5 cycles after rsp_valid.
   - Required: alu_start high for exactly 20 cycles, rsp_result=4, response stable until accepted, req_ready low throughout.
4. Modulo timeout (macro defined, TIMEOUT_CYCLES=64):
   - Stimulus: alu_done never asserted.
   - Required: rsp_err=1, rsp_result=0 after 64 MOD_RUN cycles.
   - Variant: done and the timeout in the same cycle -> rsp_err=0.
5. Reset mid-operation:
   - Stimulus: reset asserted 10 cycles into MOD_RUN.
   - Required: alu_start=0 and rsp_valid=0 immediately; after release, a new add request (7+8) gives 15.
6. Back-to-back requests:
   - Stimulus: req_valid held high with 3 queued add requests, rsp_ready=1.
   - Required: responses in order, each accepted request spaced 3 cycles apart.
